// File: rtl/dma_pkg.sv
// Shared constants, response codes and FSM state types for the DMA CSR block.
// Provides default AXI width macros when the build does not define them.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package dma_pkg;

    localparam logic [11:0] DMA_OFF_EN     = 12'h100;
    localparam logic [11:0] DMA_OFF_SRC    = 12'h200;
    localparam logic [11:0] DMA_OFF_DST    = 12'h300;
    localparam logic [11:0] DMA_OFF_LEN    = 12'h400;
    localparam logic [11:0] DMA_OFF_STATUS = 12'h500;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    function automatic logic off_mapped(input logic [11:0] off);
        return (off == DMA_OFF_EN)  || (off == DMA_OFF_SRC) ||
               (off == DMA_OFF_DST) || (off == DMA_OFF_LEN) ||
               (off == DMA_OFF_STATUS);
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_csr_regfile.sv
// DMA configuration registers, byte-strobe writes, readback mux and irq_pending.
// Full readback is enabled by DMA_CSR_READBACK_EN; otherwise only STATUS reads back.
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

import dma_pkg::*;

module dma_csr_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [11:0] wr_off_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_strb_i,
    input  logic [11:0] rd_off_i,
    output logic [31:0] rd_data_o,
    output logic        rd_err_o,
    input  logic        dma_done_i,
    output logic        en_o,
    output logic [31:0] src_o,
    output logic [31:0] dst_o,
    output logic [31:0] len_o,
    output logic        irq_o
);

    logic        en_q, en_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] len_q, len_d;
    logic        irq_q, irq_d;
    logic        irq_clr;

    always_comb begin
        en_d    = en_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        irq_d   = irq_q;
        irq_clr = 1'b0;
        if (wr_en_i) begin
            case (wr_off_i)
                DMA_OFF_EN: begin
                    if (wr_strb_i[0]) begin
                        en_d    = wr_data_i[0];
                        irq_clr = ~wr_data_i[0];
                    end
                end
                DMA_OFF_SRC:    src_d = strb_merge(src_q, wr_data_i, wr_strb_i);
                DMA_OFF_DST:    dst_d = strb_merge(dst_q, wr_data_i, wr_strb_i);
                DMA_OFF_LEN:    len_d = strb_merge(len_q, wr_data_i, wr_strb_i);
                DMA_OFF_STATUS: irq_clr = wr_strb_i[0] & wr_data_i[0];
                default: ;
            endcase
        end
        // A completion pulse in the same cycle as a clear keeps the interrupt pending.
        if (irq_clr)    irq_d = 1'b0;
        if (dma_done_i) irq_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q  <= 1'b0;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            irq_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_err_o  = ~off_mapped(rd_off_i);
        case (rd_off_i)
`ifdef DMA_CSR_READBACK_EN
            DMA_OFF_EN:     rd_data_o = {31'b0, en_q};
            DMA_OFF_SRC:    rd_data_o = src_q;
            DMA_OFF_DST:    rd_data_o = dst_q;
            DMA_OFF_LEN:    rd_data_o = len_q;
`endif
            DMA_OFF_STATUS: rd_data_o = {31'b0, irq_q};
            default: ;
        endcase
    end

    assign en_o  = en_q;
    assign src_o = src_q;
    assign dst_o = dst_q;
    assign len_o = len_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/dma_csr.sv
// AXI slave CSR block feeding the DMA engine: independent write/read FSMs over dma_csr_regfile.
// Build option DMA_CSR_READBACK_EN selects full register readback.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

import dma_pkg::*;

module dma_csr #(
    parameter logic [11:0] BASE_MASK = 12'hFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`AXI_IDS_BITS-1:0]   AWID_S,
    input  logic [`AXI_ADDR_BITS-1:0]  AWADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]   AWLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE_S,
    input  logic [1:0]                 AWBURST_S,
    input  logic                       AWVALID_S,
    output logic                       AWREADY_S,
    input  logic [`AXI_DATA_BITS-1:0]  WDATA_S,
    input  logic [`AXI_STRB_BITS-1:0]  WSTRB_S,
    input  logic                       WLAST_S,
    input  logic                       WVALID_S,
    output logic                       WREADY_S,
    output logic [`AXI_IDS_BITS-1:0]   BID_S,
    output logic [1:0]                 BRESP_S,
    output logic                       BVALID_S,
    input  logic                       BREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]   ARID_S,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
    input  logic [1:0]                 ARBURST_S,
    input  logic                       ARVALID_S,
    output logic                       ARREADY_S,
    output logic [`AXI_IDS_BITS-1:0]   RID_S,
    output logic [`AXI_DATA_BITS-1:0]  RDATA_S,
    output logic [1:0]                 RRESP_S,
    output logic                       RLAST_S,
    output logic                       RVALID_S,
    input  logic                       RREADY_S,
    output logic                       DMAEN,
    output logic [31:0]                DMASRC,
    output logic [31:0]                DMADST,
    output logic [31:0]                DMALEN,
    input  logic                       dma_done,
    output logic                       DMA_interrupt
);

    logic [11:0] aw_off;
    logic [11:0] ar_off;
    logic        wr_en;
    logic [11:0] rd_off;
    logic [31:0] rd_data;
    logic        rd_err;

    assign aw_off = AWADDR_S[11:0] & BASE_MASK;
    assign ar_off = ARADDR_S[11:0] & BASE_MASK;

    wstate_t                    wstate_q, wstate_d;
    logic [`AXI_IDS_BITS-1:0]   bid_q, bid_d;
    logic [11:0]                woff_q, woff_d;
    logic [1:0]                 bresp_q, bresp_d;

    rstate_t                    rstate_q, rstate_d;
    logic [`AXI_IDS_BITS-1:0]   rid_q, rid_d;
    logic [11:0]                roff_q, roff_d;
    logic [`AXI_LEN_BITS-1:0]   rlen_q, rlen_d;
    logic [`AXI_LEN_BITS-1:0]   rcnt_q, rcnt_d;
    logic [`AXI_DATA_BITS-1:0]  rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;

    // ---------------- write channel ----------------
    always_comb begin
        wstate_d = wstate_q;
        bid_d    = bid_q;
        woff_d   = woff_q;
        bresp_d  = bresp_q;
        wr_en    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (AWVALID_S) begin
                    bid_d    = AWID_S;
                    woff_d   = aw_off;
                    bresp_d  = off_mapped(aw_off) ? RESP_OKAY : RESP_SLVERR;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID_S) begin
                    wr_en = 1'b1;
                    if (WLAST_S) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY_S) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            bid_q    <= '0;
            woff_q   <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            bid_q    <= bid_d;
            woff_q   <= woff_d;
            bresp_q  <= bresp_d;
        end
    end

    assign AWREADY_S = (wstate_q == W_IDLE);
    assign WREADY_S  = (wstate_q == W_DATA);
    assign BVALID_S  = (wstate_q == W_RESP);
    assign BID_S     = bid_q;
    assign BRESP_S   = bresp_q;

    // ---------------- read channel ----------------
    // The read port looks at the incoming AR offset while idle so the first beat is ready at N+1.
    assign rd_off = (rstate_q == R_IDLE) ? ar_off : roff_q;

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        roff_d   = roff_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ARVALID_S) begin
                    rid_d    = ARID_S;
                    roff_d   = ar_off;
                    rlen_d   = ARLEN_S;
                    rcnt_d   = '0;
                    rdata_d  = rd_data;
                    rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY_S) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + `AXI_LEN_BITS'(1);
                        rdata_d = rd_data;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            roff_q   <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            roff_q   <= roff_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign ARREADY_S = (rstate_q == R_IDLE);
    assign RVALID_S  = (rstate_q == R_DATA);
    assign RLAST_S   = (rstate_q == R_DATA) && (rcnt_q == rlen_q);
    assign RID_S     = rid_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;

    dma_csr_regfile u_regfile (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_off_i   (woff_q),
        .wr_data_i  (WDATA_S[31:0]),
        .wr_strb_i  (WSTRB_S[3:0]),
        .rd_off_i   (rd_off),
        .rd_data_o  (rd_data),
        .rd_err_o   (rd_err),
        .dma_done_i (dma_done),
        .en_o       (DMAEN),
        .src_o      (DMASRC),
        .dst_o      (DMADST),
        .len_o      (DMALEN),
        .irq_o      (DMA_interrupt)
    );

    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE_S, AWBURST_S, ARSIZE_S, ARBURST_S, AWLEN_S,
                             AWADDR_S[`AXI_ADDR_BITS-1:12], ARADDR_S[`AXI_ADDR_BITS-1:12]};

endmodule

// File: tb/tb_dma_csr.sv
// Scoreboard testbench for dma_csr with a behavioural register-map model.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_dma_csr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [`AXI_IDS_BITS-1:0]  AWID_S = '0;
    logic [`AXI_ADDR_BITS-1:0] AWADDR_S = '0;
    logic [`AXI_LEN_BITS-1:0]  AWLEN_S = '0;
    logic [`AXI_SIZE_BITS-1:0] AWSIZE_S = '0;
    logic [1:0]                AWBURST_S = '0;
    logic                      AWVALID_S = 1'b0;
    logic                      AWREADY_S;
    logic [`AXI_DATA_BITS-1:0] WDATA_S = '0;
    logic [`AXI_STRB_BITS-1:0] WSTRB_S = '0;
    logic                      WLAST_S = 1'b0;
    logic                      WVALID_S = 1'b0;
    logic                      WREADY_S;
    logic [`AXI_IDS_BITS-1:0]  BID_S;
    logic [1:0]                BRESP_S;
    logic                      BVALID_S;
    logic                      BREADY_S = 1'b0;
    logic [`AXI_IDS_BITS-1:0]  ARID_S = '0;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_S = '0;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_S = '0;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE_S = '0;
    logic [1:0]                ARBURST_S = '0;
    logic                      ARVALID_S = 1'b0;
    logic                      ARREADY_S;
    logic [`AXI_IDS_BITS-1:0]  RID_S;
    logic [`AXI_DATA_BITS-1:0] RDATA_S;
    logic [1:0]                RRESP_S;
    logic                      RLAST_S;
    logic                      RVALID_S;
    logic                      RREADY_S = 1'b0;
    logic                      DMAEN;
    logic [31:0]               DMASRC, DMADST, DMALEN;
    logic                      dma_done = 1'b0;
    logic                      DMA_interrupt;

    dma_csr #(.BASE_MASK(12'hFFF)) dut (
        .clk(clk), .rst(rst),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
        .dma_done(dma_done), .DMA_interrupt(DMA_interrupt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic        m_en;
    logic [31:0] m_src, m_dst, m_len;
    logic        m_irq;

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit is_mapped(input logic [11:0] off);
        return off == 12'h100 || off == 12'h200 || off == 12'h300 ||
               off == 12'h400 || off == 12'h500;
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_src = '0; m_dst = '0; m_len = '0; m_irq = 1'b0;
    endtask

    task automatic model_write(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
        case (off)
            12'h100: if (s[0]) begin m_en = d[0]; if (!d[0]) m_irq = 1'b0; end
            12'h200: m_src = put_bytes(m_src, d, s);
            12'h300: m_dst = put_bytes(m_dst, d, s);
            12'h400: m_len = put_bytes(m_len, d, s);
            12'h500: if (s[0] && d[0]) m_irq = 1'b0;
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [11:0] off, output logic [31:0] d, output logic [1:0] r);
        d = '0;
        r = is_mapped(off) ? 2'b00 : 2'b10;
`ifdef DMA_CSR_READBACK_EN
        case (off)
            12'h100: d = {31'b0, m_en};
            12'h200: d = m_src;
            12'h300: d = m_dst;
            12'h400: d = m_len;
            default: ;
        endcase
`endif
        if (off == 12'h500) d = {31'b0, m_irq};
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } bexp_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    bexp_t bq[$];
    rexp_t rq[$];
    bexp_t mon_b;
    rexp_t mon_r;

    always @(negedge clk) begin
        if (!rst) begin
            if (BVALID_S && BREADY_S) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", 32'(BVALID_S), 32'h0);
                end else begin
                    mon_b = bq.pop_front();
                    chk("bid", 32'(BID_S), 32'(mon_b.id));
                    chk("bresp", 32'(BRESP_S), 32'(mon_b.resp));
                end
            end
            if (RVALID_S) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", 32'(RVALID_S), 32'h0);
                end else begin
                    mon_r = rq[0];
                    chk("rdata", RDATA_S, mon_r.data);
                    chk("rid", 32'(RID_S), 32'(mon_r.id));
                    chk("rresp", 32'(RRESP_S), 32'(mon_r.resp));
                    chk("rlast", 32'(RLAST_S), 32'(mon_r.last));
                    if (RREADY_S) void'(rq.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_outputs(input string tag);
        chk({tag, "_dmaen"}, 32'(DMAEN), 32'(m_en));
        chk({tag, "_dmasrc"}, DMASRC, m_src);
        chk({tag, "_dmadst"}, DMADST, m_dst);
        chk({tag, "_dmalen"}, DMALEN, m_len);
        chk({tag, "_irq"}, 32'(DMA_interrupt), 32'(m_irq));
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [7:0] id, input logic [31:0] data,
                             input logic [3:0] strb, input int nbeats, input bit done_last);
        bit hs;
        int t;
        logic [11:0] off;
        bexp_t be;
        off = addr[11:0];
        AWVALID_S = 1'b1; AWADDR_S = addr; AWID_S = id;
        AWLEN_S = `AXI_LEN_BITS'(nbeats - 1); AWSIZE_S = 3'd2; AWBURST_S = 2'b01;
        t = 0;
        do begin hs = AWREADY_S; tick(); t++; end while (!hs && t < 20);
        AWVALID_S = 1'b0;
        if (!hs) begin tmo("aw_handshake"); return; end
        chk("wready_n1", 32'(WREADY_S), 32'h1);
        for (int b = 0; b < nbeats; b++) begin
            WVALID_S = 1'b1; WDATA_S = data + 32'(b); WSTRB_S = strb; WLAST_S = (b == nbeats - 1);
            t = 0;
            do begin
                hs = WREADY_S;
                dma_done = done_last && (b == nbeats - 1) && hs;
                tick();
                dma_done = 1'b0;
                t++;
            end while (!hs && t < 20);
            if (!hs) begin tmo("w_handshake"); WVALID_S = 1'b0; WLAST_S = 1'b0; return; end
            model_write(off, data + 32'(b), strb);
        end
        if (done_last) m_irq = 1'b1;
        WVALID_S = 1'b0; WLAST_S = 1'b0;
        check_outputs("wr");
        chk("bvalid_rise", 32'(BVALID_S), 32'h1);
        be.id = id;
        be.resp = is_mapped(off) ? 2'b00 : 2'b10;
        bq.push_back(be);
        repeat ($urandom_range(0, 2)) tick();
        BREADY_S = 1'b1;
        t = 0;
        do begin hs = BVALID_S; tick(); t++; end while (!hs && t < 20);
        BREADY_S = 1'b0;
        if (!hs) tmo("b_handshake");
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [7:0] id, input int len,
                            input bit stall_mode);
        bit hs;
        int t, beats, stall;
        logic [31:0] ed;
        logic [1:0] er;
        rexp_t re;
        model_read(addr[11:0], ed, er);
        for (int b = 0; b <= len; b++) begin
            re.id = id; re.data = ed; re.resp = er; re.last = (b == len);
            rq.push_back(re);
        end
        ARVALID_S = 1'b1; ARADDR_S = addr; ARID_S = id; ARLEN_S = `AXI_LEN_BITS'(len);
        ARSIZE_S = 3'd2; ARBURST_S = 2'b01;
        t = 0;
        do begin hs = ARREADY_S; tick(); t++; end while (!hs && t < 20);
        ARVALID_S = 1'b0;
        if (!hs) begin tmo("ar_handshake"); rq.delete(); return; end
        chk("rvalid_n1", 32'(RVALID_S), 32'h1);
        beats = 0; t = 0; stall = 0;
        while (beats <= len && t < 200) begin
            if (stall_mode) begin
                RREADY_S = !(beats == 1 && stall < 2);
                if (!RREADY_S) stall++;
            end else begin
                RREADY_S = ($urandom_range(0, 2) != 0);
            end
            hs = RVALID_S && RREADY_S;
            tick();
            t++;
            if (hs) beats++;
        end
        RREADY_S = 1'b0;
        if (beats <= len) begin tmo("r_beats"); rq.delete(); end
        chk("r_drained", 32'(rq.size()), 32'h0);
        chk("rvalid_idle", 32'(RVALID_S), 32'h0);
    endtask

    task automatic pulse_done();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        m_irq = 1'b1;
        chk("irq_set", 32'(DMA_interrupt), 32'h1);
    endtask

    logic [11:0] offs [8] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600, 12'h104, 12'h000};

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_awready", 32'(AWREADY_S), 32'h1);
        chk("rst_arready", 32'(ARREADY_S), 32'h1);
        chk("rst_wready", 32'(WREADY_S), 32'h0);
        chk("rst_bvalid", 32'(BVALID_S), 32'h0);
        chk("rst_rvalid", 32'(RVALID_S), 32'h0);
        chk("rst_rlast", 32'(RLAST_S), 32'h0);
        chk("rst_bid", 32'(BID_S), 32'h0);
        chk("rst_rid", 32'(RID_S), 32'h0);
        chk("rst_bresp", 32'(BRESP_S), 32'h0);
        chk("rst_rresp", 32'(RRESP_S), 32'h0);
        chk("rst_rdata", RDATA_S, 32'h0);
        check_outputs("rst");

        write_txn(32'h0000_0200, 8'h05, 32'h0000_1000, 4'hF, 1, 1'b0);
        chk("src_1000", DMASRC, 32'h0000_1000);
        read_txn(32'h0000_0200, 8'h11, 0, 1'b0);

        write_txn(32'h0000_0400, 8'h06, 32'hAABB_CCDD, 4'b0101, 1, 1'b0);
        chk("len_strb", DMALEN, 32'h00BB_00DD);

        write_txn(32'h0000_0600, 8'h07, 32'hFFFF_FFFF, 4'hF, 1, 1'b0);
        read_txn(32'h0000_0600, 8'h12, 0, 1'b0);

        pulse_done();
        write_txn(32'h0000_0500, 8'h08, 32'h1, 4'h1, 1, 1'b0);
        chk("irq_clear", 32'(DMA_interrupt), 32'h0);
        pulse_done();
        write_txn(32'h0000_0500, 8'h09, 32'h1, 4'h1, 1, 1'b1);
        chk("irq_set_wins", 32'(DMA_interrupt), 32'h1);
        read_txn(32'h0000_0500, 8'h13, 0, 1'b0);

        write_txn(32'h0000_0300, 8'h0A, 32'hDEAD_BEEF, 4'hF, 2, 1'b0);
        write_txn(32'h0000_0100, 8'h0B, 32'h1, 4'hF, 1, 1'b0);
        read_txn(32'h0000_0300, 8'h14, 3, 1'b1);

        AWVALID_S = 1'b1; AWADDR_S = 32'h0000_0200; AWID_S = 8'h0C; AWLEN_S = '0;
        tick();
        AWVALID_S = 1'b0;
        chk("mid_wready", 32'(WREADY_S), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("abort_awready", 32'(AWREADY_S), 32'h1);
        chk("abort_wready", 32'(WREADY_S), 32'h0);
        chk("abort_bvalid", 32'(BVALID_S), 32'h0);
        check_outputs("abort");

        for (int i = 0; i < 60; i++) begin
            int op;
            logic [31:0] addr;
            op = $urandom_range(0, 9);
            addr = ($urandom() & 32'hFFFF_F000) | {20'h0, offs[$urandom_range(0, 7)]};
            if (op < 5)
                write_txn(addr, 8'($urandom()), $urandom(), 4'($urandom_range(0, 15)),
                          $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
            else if (op < 9)
                read_txn(addr, 8'($urandom()), $urandom_range(0, 3), 1'b0);
            else
                pulse_done();
        end

        repeat (3) tick();
        chk("bq_drained", 32'(bq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_csr.md
# dma_csr

AXI slave register block that sits directly upstream of the DMA engine. Software on the bus writes the enable, source, destination and length registers here, and these drive the DMA's `DMAEN`/`DMASRC`/`DMADST`/`DMALEN` inputs. The block also latches the engine's completion pulse into a pending bit and drives `DMA_interrupt` to the CPU. Single-outstanding write and read channels, with bursts tolerated.

## Interface
- `BASE_MASK`, default 12'hFFF: address bits decoded; upper address bits are ignored.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `AWID_S`/`AWADDR_S`/`AWLEN_S`/`AWSIZE_S`/`AWBURST_S`/`AWVALID_S` in, widths `` `AXI_IDS_BITS ``/`` `AXI_ADDR_BITS ``/`` `AXI_LEN_BITS ``/`` `AXI_SIZE_BITS ``/2/1: write address.
- `AWREADY_S` out 1: write-address ready.
- `WDATA_S`/`WSTRB_S`/`WLAST_S`/`WVALID_S` in, widths `` `AXI_DATA_BITS ``/`` `AXI_STRB_BITS ``/1/1; `WREADY_S` out 1: write data.
- `BID_S`/`BRESP_S`/`BVALID_S` out, widths `` `AXI_IDS_BITS ``/2/1; `BREADY_S` in 1: write response.
- `ARID_S`/`ARADDR_S`/`ARLEN_S`/`ARSIZE_S`/`ARBURST_S`/`ARVALID_S` in; `ARREADY_S` out 1: read address.
- `RID_S`/`RDATA_S`/`RRESP_S`/`RLAST_S`/`RVALID_S` out; `RREADY_S` in: read data.
- `DMAEN` out 1; `DMASRC`/`DMADST`/`DMALEN` out 32: configuration to the DMA engine.
- `dma_done` in 1: one-cycle completion pulse from the DMA engine.
- `DMA_interrupt` out 1: level interrupt to the CPU.

## Operation
- Register map, offset = `ADDR & BASE_MASK`:
  - 0x100 DMAEN, bit 0.
  - 0x200 DMASRC.
  - 0x300 DMADST.
  - 0x400 DMALEN.
  - 0x500 STATUS, bit 0 = irq_pending, write-1-to-clear.
- Writes honour `WSTRB_S` per byte. The 1-bit fields use byte 0 only.
- Any other offset is unmapped: writes are dropped and the response is SLVERR (2'b10); reads return 0 with SLVERR. Mapped accesses return OKAY (2'b00).
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: `AWREADY_S`=1. On the AW handshake, latch ID and offset, then go to W_DATA.
  - W_DATA: `WREADY_S`=1. Every beat writes the latched offset; the address is not incremented. On the beat with `WLAST_S`, go to W_RESP.
  - W_RESP: `BVALID_S`=1 with `BID_S`=latched ID. On `BREADY_S`, go to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: `ARREADY_S`=1. On the AR handshake, latch ID, offset and `ARLEN_S` into a beat counter, then go to R_DATA.
  - R_DATA: `RVALID_S`=1. `RLAST_S`=1 when the beat counter equals the latched length. On each `RREADY_S`, increment the counter and re-sample the register for the next beat. After the last beat, go to R_IDLE.
- `AWSIZE_S`, `AWBURST_S`, `ARSIZE_S` and `ARBURST_S` are accepted and ignored.
- irq_pending:
  - Set by `dma_done`.
  - Cleared by a STATUS write with bit 0 = 1, or by a DMAEN write with bit 0 = 0.
  - Set wins over clear in the same cycle.
- `DMA_interrupt` = irq_pending, registered.
- `DMAEN` is not auto-cleared on `dma_done`.
- The read and write FSMs are independent. A read of a register written in the same cycle returns the old value.

## Timing
- Reset values:
  - `AWREADY_S`=`ARREADY_S`=1.
  - All VALID, READY (other than AWREADY/ARREADY), LAST, ID, RESP and DATA outputs are 0.
  - `DMAEN`=0, `DMASRC`/`DMADST`/`DMALEN`=0, irq_pending=0, `DMA_interrupt`=0.
- All outputs are registered or decoded from FSM state. No combinational path from bus inputs to bus outputs.
- Write path, with the AW handshake at cycle N:
  - `WREADY_S` is high at N+1.
  - The register updates at the edge of the WLAST beat.
  - `BVALID_S` rises the cycle after the WLAST beat and holds until `BREADY_S`.
- Read path, with the AR handshake at cycle N: `RVALID_S` and `RDATA_S` are valid at N+1 and stable until `RREADY_S`.
- Interrupt: `dma_done` at cycle N gives `DMA_interrupt`=1 at N+1.
- A STATUS clear beat at cycle M gives `DMA_interrupt`=0 at M+1, unless `dma_done` also occurs at M.
- `rst` asserted mid-transaction aborts both FSMs to their idle states. No response is issued for the aborted transaction.

## Configuration
- `DMA_CSR_READBACK_EN` defined: reads return register contents as described above.
- Not defined:
  - Mapped reads return 32'h0 with OKAY.
  - STATUS still reads back irq_pending in bit 0, so interrupt polling is preserved.
  - The read handshake and timing are unchanged.

## Structure
- Shared package `dma_pkg`:
  - Register offset constants (`DMA_OFF_EN`, `DMA_OFF_SRC`, `DMA_OFF_DST`, `DMA_OFF_LEN`, `DMA_OFF_STATUS`).
  - RESP encodings (OKAY, SLVERR).
  - The `wstate_t` and `rstate_t` enums.
- One sub-module, `dma_csr_regfile`: holds the registers, byte-strobe write logic, readback mux and irq_pending logic. The top level holds the two AXI FSMs.

## Test plan
- Write 32'h0000_1000 to 0x200 with WSTRB 4'hF, AWID 8'h05 -> `DMASRC`=32'h1000, BRESP 2'b00 with `BID_S`=8'h05. Reading 0x200 returns 32'h1000 with `RLAST_S`=1.
- Write 32'hAABB_CCDD to 0x400 with WSTRB 4'b0101 over a prior value of 0 -> `DMALEN`=32'h00BB_00DD.
- Write to 0x600 -> BRESP 2'b10 and no register changes. Reading 0x600 returns 0 with RRESP 2'b10.
- Pulse `dma_done` -> `DMA_interrupt`=1 next cycle. Write 1 to 0x500 -> `DMA_interrupt`=0. Repeat with `dma_done` coinciding with the clear beat -> `DMA_interrupt` stays 1.
- Read burst with ARLEN=3 on 0x300, holding `RREADY_S` low for 2 cycles mid-burst -> 4 beats, data held stable while stalled, `RLAST_S` only on beat 4.
- Assert `rst` while in W_DATA -> `AWREADY_S`=1, `WREADY_S`=0, `BVALID_S`=0 and all registers 0 the next cycle.
